// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that shares one radix-4 Booth signed multiplier among NREQ requesters.
// Optional per-requester grant counters are enabled with `define MUL_ARB_CNT_EN.
module booth_mul_arbiter #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic [IDW-1:0]          rsp_id
`ifdef MUL_ARB_CNT_EN
  ,
  output logic [NREQ*16-1:0]      grant_cnt
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NG = (WIDTH + 1) / 2;

  logic             s1_valid;
  logic [WIDTH-1:0] op_a, op_b;
  logic [IDW-1:0]   op_id;
  logic [IDW-1:0]   prio_ptr;
  logic [IDW-1:0]   win, win_nxt;
  logic [IDW:0]     idx;
  logic             found, adv2, accept, xfer;
  logic [PW-1:0]    product;

  assign adv2   = !rsp_valid || rsp_ready;
  assign accept = !s1_valid || adv2;

  // Rotating search from prio_ptr; idx is one bit wider so the wrap works for any NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, prio_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    xfer      = found && accept && rst_n;
    if (xfer) req_ready[win] = 1'b1;
    win_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Radix-4 Booth: multiplier sign-extended to an even width, bit -1 is zero.
  logic signed [PW-1:0] a_ext, pp, prod_acc;
  logic [2*NG:0]        bx;
  logic [2:0]           sel;

  always_comb begin
    a_ext    = PW'($signed(op_a));
    bx       = {(2*NG)'($signed(op_b)), 1'b0};
    prod_acc = '0;
    pp       = '0;
    sel      = '0;
    for (int i = 0; i < int'(NG); i++) begin
      sel = bx[2*i +: 3];
      case (sel)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      prod_acc = prod_acc + (pp <<< (2 * i));
    end
  end

  assign product = prod_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      prio_ptr  <= '0;
    end else begin
      if (xfer) begin
        op_a     <= req_a[win*WIDTH +: WIDTH];
        op_b     <= req_b[win*WIDTH +: WIDTH];
        op_id    <= win;
        s1_valid <= 1'b1;
        prio_ptr <= win_nxt;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
      if (adv2) begin
        rsp_p     <= product;
        rsp_id    <= op_id;
        rsp_valid <= s1_valid;
      end
    end
  end

`ifdef MUL_ARB_CNT_EN
  // Saturating 16-bit transfer count per requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (xfer && (win == IDW'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and random bench for booth_mul_arbiter: vector table, multi-cycle sequences and a
// FIFO scoreboard of expected products.
module tb_booth_mul_arbiter;

  localparam int W   = 7;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_a, req_b;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*W-1:0]     rsp_p;
  logic [IDW-1:0]     rsp_id;
`ifdef MUL_ARB_CNT_EN
  logic [N*16-1:0]    grant_cnt;
`endif

  booth_mul_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id)
`ifdef MUL_ARB_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2*W-1:0] p;
  } item_t;

  item_t exp_q[$];
  vec_t  tab[8];
  int    checks = 0;
  int    errors = 0;
  int    xfers[N];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  function automatic int total_xfers();
    int s = 0;
    for (int i = 0; i < N; i++) s += xfers[i];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Record both handshakes of the current cycle; inputs are stable until the next negedge.
  task automatic observe();
    item_t e;
    if (rsp_valid === 1'b1 && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_extra: got id %0d p %0h, required no response", rsp_id, rsp_p);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_p", 32'(rsp_p), 32'(e.p));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        e.id = IDW'(i);
        e.p  = model(req_a[i*W +: W], req_b[i*W +: W]);
        exp_q.push_back(e);
        xfers[i]++;
      end
    end
  endtask

  task automatic tick();
    observe();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    while ((exp_q.size() != 0 || rsp_valid !== 1'b0) && n < 10) begin
      tick();
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] held_p;
    logic [IDW-1:0] held_id;
    int             n0;

    tab[0] = '{2'd0, 7'h40, 7'h40, 14'h1000};  // -64 * -64
    tab[1] = '{2'd2, 7'h3F, 7'h40, 14'h3040};  //  63 * -64
    tab[2] = '{2'd1, 7'h7F, 7'h01, 14'h3FFF};  //  -1 *   1
    tab[3] = '{2'd1, 7'h00, 7'h5B, 14'h0000};  //   0 * -37
    tab[4] = '{2'd2, 7'h7B, 7'h07, 14'h3FDD};  //  -5 *   7
    tab[5] = '{2'd0, 7'h1B, 7'h7D, 14'h3FAF};  //  27 *  -3
    tab[6] = '{2'd3, 7'h40, 7'h3F, 14'h3040};  // -64 *  63
    tab[7] = '{2'd3, 7'h3F, 7'h3F, 14'h0F81};  //  63 *  63
    for (int i = 0; i < N; i++) xfers[i] = 0;

    // Reset held with every requester valid
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    @(negedge clk);

    // Single requests from the table
    for (int v = 0; v < 8; v++) begin
      req_valid                  = '0;
      req_valid[tab[v].id]       = 1'b1;
      req_a[tab[v].id*W +: W]    = tab[v].a;
      req_b[tab[v].id*W +: W]    = tab[v].b;
      #1;
      check("single_grant", 32'(req_ready), 32'(1 << tab[v].id));
      tick();
      req_valid = '0;
      #1;
      check("single_latency", 32'(rsp_valid), 32'd0);
      tick();
      #1;
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_p", 32'(rsp_p), 32'(tab[v].p));
      check("single_id", 32'(rsp_id), 32'(tab[v].id));
      tick();
    end

    // Round robin with all requesters valid
    req_a = {7'h1B, 7'h3F, 7'h7F, 7'h40};
    req_b = {7'h7D, 7'h40, 7'h01, 7'h40};
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
      if (k >= 2) check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    drain();

    // Backpressure: two items fill the pipeline, then everything stalls
    req_valid = '1;
    rsp_ready = 1'b0;
    n0        = total_xfers();
    held_p    = '0;
    held_id   = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c >= 2) begin
        check("bp_req_ready", 32'(req_ready), 32'd0);
        if (c == 2) begin
          held_p  = rsp_p;
          held_id = rsp_id;
        end else begin
          check("bp_p_stable", 32'(rsp_p), 32'(held_p));
          check("bp_id_stable", 32'(rsp_id), 32'(held_id));
        end
      end
      tick();
    end
    check("bp_xfers", 32'(total_xfers() - n0), 32'd2);
    drain();

    // Mid-operation reset with both stages full and prio_ptr away from 0
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    repeat (2) begin
      #1;
      tick();
    end
    #1;
    check("mid_full", 32'(rsp_valid), 32'd1);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) xfers[i] = 0;
    rst_n = 1'b1;
    #1;
    check("mid_rst_ptr", 32'(req_ready), 32'b0001);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    #1;
    check("mid_rst_dropped", 32'(rsp_valid), 32'd0);
    tick();

    // Random traffic against the scoreboard
    for (int c = 0; c < 500; c++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a     = (N*W)'($urandom);
      req_b     = (N*W)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      tick();
    end
    drain();
`ifdef MUL_ARB_CNT_EN
    for (int i = 0; i < N; i++) begin
      check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(xfers[i]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
